// File: rtl/uart_pkg.sv
// Shared types for the UART transmit (and future receive) path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; writes when full
// and reads when empty are dropped so callers may drive enables freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame engine with optional parity, 1/2 stop
// bits and CTS gating checked only at frame start; queued frames go out with no gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BITS_N-1:0]             data_tx,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          cts,
  output logic                          uart_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(BITS_N);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST  = IDX_W'(BITS_N - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic [BITS_N-1:0]   shift_q, shift_d;
  logic                parity_q, parity_d;
  logic                uart_q, uart_d;

  logic                fifo_full, fifo_empty, pop, load, bit_done;
  logic [BITS_N-1:0]   fifo_rd_data;

  sync_fifo #(
    .WIDTH (BITS_N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid),
    .wr_data (data_tx),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign ready    = !fifo_full;
  assign busy     = (state_q != IDLE);
  assign uart_out = uart_q;
  assign bit_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    load       = 1'b0;
    pop        = 1'b0;
    uart_d     = 1'b1;

    if (state_q != IDLE) baud_d = bit_done ? '0 : baud_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        load   = !fifo_empty && cts;
      end
      START_BIT: begin
        if (bit_done) begin
          state_d   = DATA_BITS;
          bit_idx_d = '0;
        end
      end
      DATA_BITS: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            state_d    = (PARITY_TYPE != PARITY_NONE) ? PARITY_BIT : STOP_BIT;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY_BIT: begin
        if (bit_done) begin
          state_d    = STOP_BIT;
          stop_idx_d = 1'b0;
        end
      end
      STOP_BIT: begin
        if (bit_done) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = IDLE;
            load    = !fifo_empty && cts;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading from IDLE or the final stop cycle gives zero-gap back-to-back frames.
    if (load) begin
      pop        = 1'b1;
      shift_d    = fifo_rd_data;
      parity_d   = (PARITY_TYPE == PARITY_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
      state_d    = START_BIT;
      baud_d     = '0;
      bit_idx_d  = '0;
      stop_idx_d = 1'b0;
    end

    unique case (state_d)
      START_BIT:  uart_d = 1'b0;
      DATA_BITS:  uart_d = shift_d[0];
      PARITY_BIT: uart_d = parity_d;
      default:    uart_d = 1'b1;
    endcase
  end

  // The line is registered from next-state so the pin never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      uart_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      uart_q     <= uart_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: four DUT instances (default, even parity, odd parity, two stop bits).
module tb_uart_tx_buffered;

  logic            clk;
  logic            rst;
  logic [3:0][7:0] data;
  logic [3:0]      valid;
  logic [3:0]      cts;
  logic [3:0]      rdy;
  logic [3:0]      uo;
  logic [3:0]      by;
  logic [3:0][2:0] fc;

  int n_cmp;
  int n_err;
  int bcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .data_tx(data[0]), .valid(valid[0]), .ready(rdy[0]),
    .cts(cts[0]), .uart_out(uo[0]), .busy(by[0]), .fifo_count(fc[0]));

  uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .data_tx(data[1]), .valid(valid[1]), .ready(rdy[1]),
    .cts(cts[1]), .uart_out(uo[1]), .busy(by[1]), .fifo_count(fc[1]));

  uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .data_tx(data[2]), .valid(valid[2]), .ready(rdy[2]),
    .cts(cts[2]), .uart_out(uo[2]), .busy(by[2]), .fifo_count(fc[2]));

  uart_tx_buffered #(.CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .data_tx(data[3]), .valid(valid[3]), .ready(rdy[3]),
    .cts(cts[3]), .uart_out(uo[3]), .busy(by[3]), .fifo_count(fc[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    @(negedge clk);
    data[i]  = d;
    valid[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  // Starts on the negedge before the start-bit cycle; checks every cycle of the frame.
  task automatic expect_frame(input int i, input logic [7:0] d, input int pt, input int sb);
    logic [11:0] bits;
    int          n;
    bits    = '1;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[1+k] = d[k];
    n = 9;
    if (pt != 0) begin
      bits[n] = (pt == 2) ? ^d : ~^d;
      n++;
    end
    n += sb;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("dut%0d_d%02h_bit%0d_c%0d", i, d, b, c), 32'(uo[i]), 32'(bits[b]));
        if (by[i]) bcnt++;
      end
    end
  endtask

  initial begin
    int bad;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    cts   = 4'b0111;
    #1;
    chk("rst_uart_out", 32'(uo), 32'hF);
    chk("rst_ready", 32'(rdy), 32'hF);
    chk("rst_busy", 32'(by), 32'h0);
    chk("rst_count0", 32'(fc[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single 0xA5 frame
    push(0, 8'hA5);
    bcnt = 0;
    expect_frame(0, 8'hA5, 0, 1);
    chk("t1_busy_cycles", 32'(bcnt), 32'd40);
    @(negedge clk);
    chk("t1_idle_busy", 32'(by[0]), 32'd0);
    chk("t1_idle_line", 32'(uo[0]), 32'd1);

    // 2: fill with cts low, overflow ignored, then four frames back-to-back
    cts[0] = 1'b0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    push(0, 8'h44);
    chk("t2_count_full", 32'(fc[0]), 32'd4);
    chk("t2_ready_low", 32'(rdy[0]), 32'd0);
    push(0, 8'h55);
    chk("t2_count_after_ovf", 32'(fc[0]), 32'd4);
    chk("t2_line_idle_cts_low", 32'(uo[0]), 32'd1);
    cts[0] = 1'b1;
    bcnt = 0;
    expect_frame(0, 8'h11, 0, 1);
    expect_frame(0, 8'h22, 0, 1);
    expect_frame(0, 8'h33, 0, 1);
    expect_frame(0, 8'h44, 0, 1);
    chk("t2_busy_cycles", 32'(bcnt), 32'd160);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (uo[0] !== 1'b1 || by[0] !== 1'b0) bad++;
    end
    chk("t2_no_fifth_frame", 32'(bad), 32'd0);
    chk("t2_count_empty", 32'(fc[0]), 32'd0);

    // 3: even and odd parity on 0x07
    push(1, 8'h07);
    bcnt = 0;
    expect_frame(1, 8'h07, 2, 1);
    chk("t3_even_frame_cycles", 32'(bcnt), 32'd44);
    push(2, 8'h07);
    bcnt = 0;
    expect_frame(2, 8'h07, 1, 1);
    chk("t3_odd_frame_cycles", 32'(bcnt), 32'd44);

    // 4: two stop bits between 0x00 and 0xFF
    push(3, 8'h00);
    push(3, 8'hFF);
    cts[3] = 1'b1;
    expect_frame(3, 8'h00, 0, 2);
    expect_frame(3, 8'hFF, 0, 2);
    @(negedge clk);
    chk("t4_idle_after", 32'(by[3]), 32'd0);

    // 5: cts dropped mid-frame holds the second byte
    cts[0] = 1'b0;
    push(0, 8'h3C);
    push(0, 8'hC3);
    cts[0] = 1'b1;
    fork
      expect_frame(0, 8'h3C, 0, 1);
      begin
        repeat (10) @(negedge clk);
        cts[0] = 1'b0;
      end
    join
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (uo[0] !== 1'b1 || by[0] !== 1'b0 || fc[0] !== 3'd1) bad++;
    end
    chk("t5_held_idle", 32'(bad), 32'd0);
    cts[0] = 1'b1;
    expect_frame(0, 8'hC3, 0, 1);

    // 6: asynchronous reset mid-data with two bytes queued
    cts[0] = 1'b0;
    push(0, 8'h81);
    push(0, 8'h42);
    push(0, 8'h24);
    cts[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_busy_before", 32'(by[0]), 32'd1);
    chk("t6_count_before", 32'(fc[0]), 32'd2);
    chk("t6_line_data", 32'(uo[0]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_line", 32'(uo[0]), 32'd1);
    chk("t6_rst_busy", 32'(by[0]), 32'd0);
    chk("t6_rst_count", 32'(fc[0]), 32'd0);
    chk("t6_rst_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (uo[0] !== 1'b1 || by[0] !== 1'b0) bad++;
    end
    chk("t6_no_frames_after", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
